// File: rtl/dekatron_bcd_counter.sv
// dekatron_bcd_counter: multi-digit BCD up/down counter, one 4-bit digit per
// dekatron tube. Steps by one per accepted Request/Ready handshake or loads a
// sanitized parallel value. Optional top limit wraps the count at TOP_VALUE.
// Optional feature macro: DEKATRON_COUNTER_WRAP_FLAG_EN adds a one-cycle Wrap
// output that flags a step which wrapped around the range.
module dekatron_bcd_counter #(
    parameter int              D_NUM          = 3,
    parameter bit              TOP_LIMIT_MODE = 1'b0,
    parameter logic [4*D_NUM-1:0] TOP_VALUE   = {D_NUM{4'd9}}
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Request,
    input  logic               Dec,
    input  logic               Set,
    input  logic [4*D_NUM-1:0] In,
    output logic               Ready,
    output logic [4*D_NUM-1:0] Out
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
    ,
    output logic               Wrap
`endif
);

    localparam int W = 4 * D_NUM;

    // Highest legal count: TOP_VALUE in top-limit mode, all nines otherwise.
    localparam logic [W-1:0] RANGE_TOP = TOP_LIMIT_MODE ? TOP_VALUE : {D_NUM{4'd9}};

    logic [W-1:0] out_q, out_d;
    logic         ready_q, ready_d;
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
    logic         wrap_q, wrap_d;
`endif

    // Force every digit into 0..9, then clamp to the range top. With all
    // digits valid BCD, a plain unsigned compare is a BCD magnitude compare.
    function automatic logic [W-1:0] sanitize(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < D_NUM; k++) begin
            r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd0 : v[4*k +: 4];
        end
        if (r > RANGE_TOP) begin
            r = RANGE_TOP;
        end
        return r;
    endfunction

    // BCD +1 with the carry rippling through all digits in one evaluation.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         carry;
        r     = '0;
        carry = 1'b1;
        for (int k = 0; k < D_NUM; k++) begin
            d = v[4*k +: 4];
            if (carry) begin
                if (d == 4'd9) begin
                    d = 4'd0;
                end else begin
                    d     = d + 4'd1;
                    carry = 1'b0;
                end
            end
            r[4*k +: 4] = d;
        end
        return r;
    endfunction

    // BCD -1 with the borrow rippling through all digits in one evaluation.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic [3:0]   d;
        logic         borrow;
        r      = '0;
        borrow = 1'b1;
        for (int k = 0; k < D_NUM; k++) begin
            d = v[4*k +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d = 4'd9;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[4*k +: 4] = d;
        end
        return r;
    endfunction

    // Next-state: Set wins over a step; a step needs Request with Ready high.
    always_comb begin
        out_d   = out_q;
        ready_d = 1'b1;
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
        wrap_d  = 1'b0;
`endif
        if (Set) begin
            out_d   = sanitize(In);
            ready_d = 1'b0;
        end else if (Request && ready_q) begin
            if (Dec) begin
                if (out_q == '0) begin
                    out_d = RANGE_TOP;
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
                    wrap_d = 1'b1;
`endif
                end else begin
                    out_d = bcd_dec(out_q);
                end
            end else begin
                if (out_q == RANGE_TOP) begin
                    out_d = '0;
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
                    wrap_d = 1'b1;
`endif
                end else begin
                    out_d = bcd_inc(out_q);
                end
            end
        end
    end

    // State registers with synchronous active-low reset overriding everything.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            out_q   <= '0;
            ready_q <= 1'b0;
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
            wrap_q  <= 1'b0;
`endif
        end else begin
            out_q   <= out_d;
            ready_q <= ready_d;
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
            wrap_q  <= wrap_d;
`endif
        end
    end

    assign Out   = out_q;
    assign Ready = ready_q;
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
    assign Wrap  = wrap_q;
`endif

endmodule

// File: tb/tb_dekatron_bcd_counter.sv
// Bench for dekatron_bcd_counter: one instance with a 0x255 top limit and one
// full-range instance. Wrap checks compile in with DEKATRON_COUNTER_WRAP_FLAG_EN.
module tb_dekatron_bcd_counter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        t_req, t_dec, t_set, t_ready;
    logic [11:0] t_in, t_out;
    logic        f_req, f_dec, f_set, f_ready;
    logic [11:0] f_in, f_out;
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
    logic        t_wrap, f_wrap;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dekatron_bcd_counter #(
        .D_NUM(3), .TOP_LIMIT_MODE(1'b1), .TOP_VALUE(12'h255)
    ) dut_t (
        .Clk(clk), .Rst_n(rst_n), .Request(t_req), .Dec(t_dec), .Set(t_set),
        .In(t_in), .Ready(t_ready), .Out(t_out)
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
        , .Wrap(t_wrap)
`endif
    );

    dekatron_bcd_counter #(
        .D_NUM(3), .TOP_LIMIT_MODE(1'b0), .TOP_VALUE(12'h999)
    ) dut_f (
        .Clk(clk), .Rst_n(rst_n), .Request(f_req), .Dec(f_dec), .Set(f_set),
        .In(f_in), .Ready(f_ready), .Out(f_out)
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
        , .Wrap(f_wrap)
`endif
    );

    typedef struct {
        logic        set;
        logic        req;
        logic        dec;
        logic [11:0] din;
        logic [11:0] exp_out;
        logic        exp_ready;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

    function automatic logic [11:0] bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'h998, 12'h998, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h998, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h999, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h000, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, 12'h3A7, 12'h307, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h307, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 12'h123, 12'h123, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h123, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 12'h000, 12'h122, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 12'h099, 12'h099, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h099, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 12'h000, 12'h100, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 12'h000, 12'h099, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 1'b0, 12'h000, 12'h000, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 1'b1, 12'h000, 12'h999, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 12'hFAF, 12'h000, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 12'h000, 12'h000, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 12'h0C9, 12'h009, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 12'h000, 12'h009, 1'b1};
        vecs[20] = '{1'b0, 1'b1, 1'b1, 12'h000, 12'h008, 1'b1};

        // Reset held with Set/Request active: reset must win.
        rst_n = 1'b0;
        t_req = 1'b1; t_dec = 1'b0; t_set = 1'b1; t_in = 12'h123;
        f_req = 1'b1; f_dec = 1'b0; f_set = 1'b1; f_in = 12'h456;
        tick();
        chk("reset_t_out", t_out, 12'h000);
        chk("reset_t_ready", {11'b0, t_ready}, 12'h000);
        chk("reset_f_out", f_out, 12'h000);
        chk("reset_f_ready", {11'b0, f_ready}, 12'h000);
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
        chk("reset_t_wrap", {11'b0, t_wrap}, 12'h000);
`endif
        rst_n = 1'b1;
        t_req = 1'b0; t_set = 1'b0; t_in = 12'h000;
        f_req = 1'b0; f_set = 1'b0; f_in = 12'h000;
        tick();
        chk("post_reset_t_out", t_out, 12'h000);
        chk("post_reset_t_ready", {11'b0, t_ready}, 12'h001);
        chk("post_reset_f_ready", {11'b0, f_ready}, 12'h001);

        // 50 increment pulses, one every two cycles.
        for (int i = 1; i <= 50; i++) begin
            t_req = 1'b1; t_dec = 1'b0;
            tick();
            t_req = 1'b0;
            chk("inc_pulse", t_out, bcd(i));
            tick();
        end
        chk("inc_pulse_hold", t_out, 12'h050);

        // 50 decrement pulses back to zero.
        for (int i = 49; i >= 0; i--) begin
            t_req = 1'b1; t_dec = 1'b1;
            tick();
            t_req = 1'b0;
            chk("dec_pulse", t_out, bcd(i));
            tick();
        end

        // 256 back-to-back increments through the 0x255 top.
        t_req = 1'b1; t_dec = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            chk("inc_run", t_out, (k == 256) ? 12'h000 : bcd(k));
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
            chk("inc_run_wrap", {11'b0, t_wrap}, (k == 256) ? 12'h001 : 12'h000);
`endif
        end
        t_req = 1'b0;

        // Decrement from zero lands on the top.
        t_req = 1'b1; t_dec = 1'b1;
        tick();
        t_req = 1'b0;
        chk("dec_wrap_out", t_out, 12'h255);
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
        chk("dec_wrap_flag", {11'b0, t_wrap}, 12'h001);
`endif
        tick();
        chk("dec_wrap_hold", t_out, 12'h255);
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
        chk("dec_wrap_flag_clear", {11'b0, t_wrap}, 12'h000);
`endif

        // Loads against the 0x255 limit.
        t_set = 1'b1; t_in = 12'h300;
        tick();
        chk("clamp_300", t_out, 12'h255);
        chk("clamp_ready", {11'b0, t_ready}, 12'h000);
`ifdef DEKATRON_COUNTER_WRAP_FLAG_EN
        chk("set_no_wrap", {11'b0, t_wrap}, 12'h000);
`endif
        t_in = 12'h2A9;
        tick();
        chk("sanitize_2A9", t_out, 12'h209);
        t_in = 12'h256;
        tick();
        chk("clamp_256", t_out, 12'h255);
        t_in = 12'h254;
        tick();
        chk("load_254", t_out, 12'h254);
        t_set = 1'b0;
        tick();
        chk("ready_after_load", {11'b0, t_ready}, 12'h001);
        t_req = 1'b1; t_dec = 1'b0;
        tick();
        chk("inc_to_top", t_out, 12'h255);
        tick();
        chk("inc_top_wrap", t_out, 12'h000);
        t_req = 1'b0;

        // Full-range vector table.
        for (int v = 0; v < NVEC; v++) begin
            f_set = vecs[v].set; f_req = vecs[v].req;
            f_dec = vecs[v].dec; f_in  = vecs[v].din;
            tick();
            chk($sformatf("vec%0d_out", v), f_out, vecs[v].exp_out);
            chk($sformatf("vec%0d_ready", v), {11'b0, f_ready}, {11'b0, vecs[v].exp_ready});
        end
        f_set = 1'b0; f_req = 1'b0; f_dec = 1'b0;

        // Reset asserted while steps are in flight.
        t_req = 1'b1; t_dec = 1'b0; f_req = 1'b1; f_dec = 1'b0;
        tick();
        tick();
        chk("midrun_stepping", t_out, 12'h002);
        rst_n = 1'b0;
        tick();
        chk("midrun_reset_t_out", t_out, 12'h000);
        chk("midrun_reset_t_ready", {11'b0, t_ready}, 12'h000);
        chk("midrun_reset_f_out", f_out, 12'h000);
        rst_n = 1'b1;
        t_req = 1'b0; f_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
